// File: rtl/row_denormalization_pkg.sv
// Shared constants and helpers for the row denormalization datapath.
// Holds word/fraction lengths, the 1/K shift-add set and the FSM states.
package row_denormalization_pkg;

    // Word length and fraction length of every H/y component.
    localparam int WL  = 16;
    localparam int FWL = 12;

    // 1/K ~= 1.646728 quantized to FWL bits: 6745/4096.
    // 6745 = 2^0 + 2^3 + 2^4 + 2^6 + 2^9 + 2^11 + 2^12.
    localparam int INV_K    = 6745;
    localparam int INV_K_S0 = 0;
    localparam int INV_K_S1 = 3;
    localparam int INV_K_S2 = 4;
    localparam int INV_K_S3 = 6;
    localparam int INV_K_S4 = 9;
    localparam int INV_K_S5 = 11;
    localparam int INV_K_S6 = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Full-precision in * 6745 built from the shift set, 2*WL wide.
    function automatic logic signed [2*WL-1:0] inv_k_mul(
        input logic signed [WL-1:0] v
    );
        logic signed [2*WL-1:0] e;
        e = {{WL{v[WL-1]}}, v};
        return (e <<< INV_K_S0) + (e <<< INV_K_S1)
             + (e <<< INV_K_S2) + (e <<< INV_K_S3)
             + (e <<< INV_K_S4) + (e <<< INV_K_S5)
             + (e <<< INV_K_S6);
    endfunction

endpackage

// File: rtl/denormalization_unit.sv
// Combinational 1/K scaler: dout = floor(din * 6745 / 4096), WL in / WL out.
// Ports: din (WL), dout (WL). Macro DENORM_SAT_EN clamps instead of wrapping.
module denormalization_unit
    import row_denormalization_pkg::*;
(
    input  logic [WL-1:0] din,
    output logic [WL-1:0] dout
);

`ifdef DENORM_SAT_EN
    localparam logic signed [2*WL-1:0] SMAX =
        {{(WL+1){1'b0}}, {(WL-1){1'b1}}};
    localparam logic signed [2*WL-1:0] SMIN =
        {{(WL+1){1'b1}}, {(WL-1){1'b0}}};

    logic signed [2*WL-1:0] q;

    always_comb begin
        // Arithmetic shift gives floor rounding of the product.
        q = inv_k_mul(din) >>> FWL;
        if (q > SMAX) begin
            dout = {1'b0, {(WL-1){1'b1}}};
        end else if (q < SMIN) begin
            dout = {1'b1, {(WL-1){1'b0}}};
        end else begin
            dout = q[WL-1:0];
        end
    end
`else
    // Plain slice of bits [FWL+WL-1:FWL]; overflow wraps.
    always_comb begin
        dout = WL'(inv_k_mul(din) >>> FWL);
    end
`endif

endmodule

// File: rtl/row_denormalization.sv
// Row denormalization: scales N H elements plus y by 1/K, one element/cycle.
// Ports: clk, rst_n, in_valid/in_ready + Hin_x/Hin_y/yin_x/yin_y,
//        out_valid/out_ready + Hout_x/Hout_y/yout_x/yout_y.
// Build option: DENORM_SAT_EN selects saturation in denormalization_unit.
module row_denormalization
    import row_denormalization_pkg::*;
#(
    parameter int N = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [WL*N-1:0] Hin_x,
    input  logic [WL*N-1:0] Hin_y,
    input  logic [WL-1:0]   yin_x,
    input  logic [WL-1:0]   yin_y,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [WL*N-1:0] Hout_x,
    output logic [WL*N-1:0] Hout_y,
    output logic [WL-1:0]   yout_x,
    output logic [WL-1:0]   yout_y
);

    localparam int CW = $clog2(N + 1);
    localparam int RW = WL * (N + 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    // Row and result registers: slot i<N is H[i], slot N is y.
    logic [RW-1:0]   rx_q, ry_q;
    logic [RW-1:0]   ox_q, oy_q;

    logic [WL-1:0]   sel_x, sel_y;
    logic [WL-1:0]   den_x, den_y;
    logic            accept;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign accept    = in_valid & in_ready;

    assign sel_x = rx_q[cnt_q*WL +: WL];
    assign sel_y = ry_q[cnt_q*WL +: WL];

    denormalization_unit u_den_x (
        .din  (sel_x),
        .dout (den_x)
    );

    denormalization_unit u_den_y (
        .din  (sel_y),
        .dout (den_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (cnt_q == CW'(N)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_q <= '0;
            ry_q <= '0;
            ox_q <= '0;
            oy_q <= '0;
        end else begin
            if (accept) begin
                rx_q <= {yin_x, Hin_x};
                ry_q <= {yin_y, Hin_y};
            end
            if (state_q == RUN) begin
                ox_q[cnt_q*WL +: WL] <= den_x;
                oy_q[cnt_q*WL +: WL] <= den_y;
            end
        end
    end

    assign Hout_x = ox_q[WL*N-1:0];
    assign Hout_y = oy_q[WL*N-1:0];
    assign yout_x = ox_q[WL*N +: WL];
    assign yout_y = oy_q[WL*N +: WL];

endmodule

// File: tb/tb_row_denormalization.sv
// Self-checking bench for row_denormalization (N=4) with a reference model.
// Honours DENORM_SAT_EN for the overflow expectations.
module tb_row_denormalization;

    localparam int WL = 16;
    localparam int N  = 4;

    typedef struct packed {
        logic [WL*N-1:0] hx;
        logic [WL*N-1:0] hy;
        logic [WL-1:0]   yx;
        logic [WL-1:0]   yy;
    } row_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [WL*N-1:0] Hin_x, Hin_y;
    logic [WL-1:0]   yin_x, yin_y;
    logic            out_valid;
    logic            out_ready;
    logic [WL*N-1:0] Hout_x, Hout_y;
    logic [WL-1:0]   yout_x, yout_y;

    int   vectors    = 0;
    int   miscompares = 0;
    bit   rand_rdy   = 1'b0;
    row_t expq[$];
    row_t mon_e;

    row_denormalization #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Hin_x     (Hin_x),
        .Hin_y     (Hin_y),
        .yin_x     (yin_x),
        .yin_y     (yin_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Hout_x    (Hout_x),
        .Hout_y    (Hout_y),
        .yout_x    (yout_x),
        .yout_y    (yout_y)
    );

    always #5 clk = ~clk;

    // Reference: floor(v * 6745 / 4096), then clamp or wrap to 16 bits.
    function automatic logic [WL-1:0] scale(input logic [WL-1:0] v);
        logic signed [WL-1:0] s;
        longint p;
        s = v;
        p = s;
        p = p * 6745;
        p = p >>> 12;
`ifdef DENORM_SAT_EN
        if (p > 32767)  p = 32767;
        if (p < -32768) p = -32768;
`endif
        return p[WL-1:0];
    endfunction

    function automatic row_t model(input row_t r);
        row_t o;
        for (int i = 0; i < N; i++) begin
            o.hx[WL*i +: WL] = scale(r.hx[WL*i +: WL]);
            o.hy[WL*i +: WL] = scale(r.hy[WL*i +: WL]);
        end
        o.yx = scale(r.yx);
        o.yy = scale(r.yy);
        return o;
    endfunction

    function automatic int el(input logic [WL*N-1:0] v, input int i);
        logic signed [WL-1:0] t;
        t = v[WL*i +: WL];
        return int'(t);
    endfunction

    function automatic int sv16(input logic [WL-1:0] v);
        logic signed [WL-1:0] t;
        t = v;
        return int'(t);
    endfunction

    function automatic logic [WL*N-1:0] pk4(
        input int a, input int b, input int c, input int d
    );
        return {d[WL-1:0], c[WL-1:0], b[WL-1:0], a[WL-1:0]};
    endfunction

    function automatic logic [WL-1:0] rv();
        int k;
        int r;
        k = $urandom_range(0, 7);
        r = $urandom;
        case (k)
            0: r = 32767;
            1: r = -32768;
            2: r = -1;
            3: r = 1;
            4: r = 0;
            default: r = r;
        endcase
        return r[WL-1:0];
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Compare every cycle the DUT presents a row.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (expq.size() == 0) begin
                chk("spurious_out_valid", 1, 0);
            end else begin
                mon_e = expq[0];
                for (int i = 0; i < N; i++) begin
                    chk($sformatf("hx%0d", i), el(Hout_x, i), el(mon_e.hx, i));
                    chk($sformatf("hy%0d", i), el(Hout_y, i), el(mon_e.hy, i));
                end
                chk("yx", sv16(yout_x), sv16(mon_e.yx));
                chk("yy", sv16(yout_y), sv16(mon_e.yy));
                chk("in_ready_in_done", int'(in_ready), 0);
                if (out_ready) void'(expq.pop_front());
            end
        end
    end

    // All drive steps happen 1 time unit after a rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input row_t r);
        int n;
        row_t rr;
        rr = r;
        Hin_x = rr.hx;
        Hin_y = rr.hy;
        yin_x = rr.yx;
        yin_y = rr.yy;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 300) begin
            step();
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", n, 0);
        end else begin
            @(posedge clk);
            expq.push_back(model(rr));
            #1;
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 50) begin
            step();
            cyc++;
        end
        if (!out_valid) chk("valid_timeout", cyc, -1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (expq.size() != 0 && n < 300) begin
            step();
            n++;
        end
        if (expq.size() != 0) chk("drain_timeout", expq.size(), 0);
    endtask

    initial begin
        row_t r;
        int   lat;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        Hin_x = '0; Hin_y = '0; yin_x = '0; yin_y = '0;

        // Model pinned to hand-computed values.
        chk("m_one",   sv16(scale(16'd4096)), 6745);
        chk("m_neg1",  sv16(scale(16'hFFFF)), -2);
        chk("m_half",  sv16(scale(16'd2048)), 3372);
        chk("m_rt",    sv16(scale(16'd2487)), 4095);

        #12;
        chk("rst_in_ready",  int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_hout_x",    int'(Hout_x != '0), 0);
        chk("rst_yout_y",    int'(yout_y), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();

        // Single element, latency check.
        r = '0;
        r.hx = pk4(4096, 0, 0, 0);
        send(r);
        wait_valid(lat);
        chk("latency", lat, 5);
        chk("lit_hx0", el(Hout_x, 0), 6745);
        chk("lit_hx1", el(Hout_x, 1), 0);
        chk("lit_yx0", sv16(yout_x), 0);
        drain();

        // Sign, truncation, round trip and overflow.
        r.hx = pk4(2487, 20000, -20000, -2487);
        r.hy = pk4(0, 0, -1, 1);
        r.yx = 16'hF000;
        r.yy = 16'd2048;
        send(r);
        wait_valid(lat);
        chk("lit_rt_pos", el(Hout_x, 0), 4095);
        chk("lit_rt_neg", el(Hout_x, 3), -4096);
        chk("lit_hy2",    el(Hout_y, 2), -2);
        chk("lit_hy3",    el(Hout_y, 3), 1);
        chk("lit_yx",     sv16(yout_x), -6745);
        chk("lit_yy",     sv16(yout_y), 3372);
`ifdef DENORM_SAT_EN
        chk("lit_ovf_pos", el(Hout_x, 1), 32767);
        chk("lit_ovf_neg", el(Hout_x, 2), -32768);
`else
        chk("lit_ovf_pos", el(Hout_x, 1), -32602);
        chk("lit_ovf_neg", el(Hout_x, 2), 32601);
`endif
        drain();

        // Backpressure with a second row waiting.
        out_ready = 1'b0;
        r.hx = pk4(100, -200, 300, -400);
        r.hy = pk4(-5, 6, -7, 8);
        r.yx = 16'd1234;
        r.yy = 16'hFC00;
        send(r);
        wait_valid(lat);
        r.hx = pk4(-1000, 2000, -3000, 4000);
        r.hy = pk4(11, -12, 13, -14);
        r.yx = 16'd77;
        r.yy = 16'd88;
        Hin_x = r.hx; Hin_y = r.hy; yin_x = r.yx; yin_y = r.yy;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_in_ready",  int'(in_ready), 0);
            chk("bp_out_valid", int'(out_valid), 1);
        end
        out_ready = 1'b1;
        step();
        chk("bp_release_in_ready",  int'(in_ready), 1);
        chk("bp_release_out_valid", int'(out_valid), 0);
        chk("bp_one_handshake",     expq.size(), 0);
        @(posedge clk);
        expq.push_back(model(r));
        #1;
        in_valid = 1'b0;
        drain();

        // Reset in the middle of RUN.
        r.hx = pk4(9999, -9999, 1, 2);
        r.hy = pk4(3, 4, 5, 6);
        r.yx = 16'd7;
        r.yy = 16'd8;
        send(r);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        expq.delete();
        chk("mr_out_valid", int'(out_valid), 0);
        chk("mr_in_ready",  int'(in_ready), 1);
        chk("mr_hout_x",    int'(Hout_x != '0), 0);
        chk("mr_hout_y",    int'(Hout_y != '0), 0);
        chk("mr_yout",      int'({yout_x, yout_y} != '0), 0);
        step();
        rst_n = 1'b1;
        step();
        r.hx = pk4(-4096, 4096, 8191, -8192);
        r.hy = pk4(1, -1, 2, -2);
        r.yx = 16'd4096;
        r.yy = 16'hF000;
        send(r);
        drain();

        // Randomized rows with random backpressure.
        rand_rdy = 1'b1;
        for (int k = 0; k < 60; k++) begin
            for (int i = 0; i < N; i++) begin
                r.hx[WL*i +: WL] = rv();
                r.hy[WL*i +: WL] = rv();
            end
            r.yx = rv();
            r.yy = rv();
            send(r);
            repeat ($urandom_range(0, 3)) step();
        end
        drain();
        rand_rdy  = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/row_denormalization.md
Name: row_denormalization

Overview:
- Restores the CORDIC-gain-compensated scale of one channel-matrix row plus its receive sample.
- Multiplies every element by 1/K ≈ 1.646728 (6745/4096, FWL 12). This is the inverse of the row normalization stage.
- Sits on the output side of the QR/detector datapath, ahead of any consumer that needs unscaled H/y.
- Time-multiplexes one complex shift-add multiplier pair over the N+1 elements of a row, with valid/ready handshakes on both sides.

Parameters:
- N, 1, number of complex H elements per row (1..8).
- `WL / `FWL, from parameters.v (16 / 12 in the default build), word length and fraction length.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  row offered.
- in_ready  output  1  block can accept a row.
- Hin_x  input  `WL*N  packed real parts, element i at [`WL*i +: `WL].
- Hin_y  input  `WL*N  packed imaginary parts.
- yin_x  input  `WL  receive sample, real part.
- yin_y  input  `WL  receive sample, imaginary part.
- out_valid  output  1  denormalized row available.
- out_ready  input  1  downstream accepts the row.
- Hout_x  output  `WL*N  packed scaled real parts.
- Hout_y  output  `WL*N  packed scaled imaginary parts.
- yout_x  output  `WL  scaled y, real part.
- yout_y  output  `WL  scaled y, imaginary part.

Behaviour:
- Reset (async, rst_n=0): state IDLE, in_ready=1, out_valid=0, all data outputs 0, element counter 0. Reset mid-row discards the row with no partial output.
- States:
  - IDLE: in_ready=1. A cycle with in_valid&in_ready captures all inputs into an internal row register and moves to RUN with cnt=0.
  - RUN: in_ready=0. Each cycle scales element cnt (0..N-1 = H[cnt], N = y), real and imaginary in parallel, and writes the result into the output register slot; cnt increments. When cnt==N the y slot is written and the state moves to DONE.
  - DONE: out_valid=1; outputs held stable. A cycle with out_valid&out_ready moves to IDLE, and out_valid drops the next cycle.
- No overlap: a new row is accepted only in IDLE, and in_ready rises the cycle after the handshake. Minimum accept-to-out_valid latency is N+1 cycles. Throughput is one row per N+3 cycles with out_ready held high.
- Scaling per element: out = (in * 6745) >>> 12, using in sign-extended to 2*`WL and the sum of in<<<{0,3,4,6,9,11,12}. This is an arithmetic floor (truncate toward −inf), the same truncation convention as the normalization stage.
- Result bits [`FWL+`WL-1:`FWL] are taken after the overflow handling defined under the optional feature.
- Output registers change only in RUN; downstream may sample them any cycle out_valid=1.

Optional Feature:
- DENORM_SAT_EN defined: before slicing, a result above 2^(`WL-1)-1 clamps to 2^(`WL-1)-1 and one below −2^(`WL-1) clamps to −2^(`WL-1).
- DENORM_SAT_EN undefined: plain slice, two's-complement wrap on overflow. Smaller area.
- Cycle timing is identical in both builds.

Decomposition:
- parameters.v gains the INV_K shift-set constants (shift amounts 0,3,4,6,9,11,12 and integer 6745) so normalization and denormalization constants live together.
- One sub-module: denormalization_unit. It is combinational, `WL in / `WL out, and holds the shift-add and optional saturation. It is instantiated twice (x and y). The FSM and counter live in row_denormalization.

Test Plan:
- Single element, N=4, Hin_x[0]=4096 (1.0), all others 0 -> Hout_x[0]=6745, all others 0. out_valid asserts exactly 5 cycles after the accept edge.
- Sign/truncation: yin_x=−4096 -> −6745; yin_y=2048 -> 3372; Hin_y[3]=1 -> 1; Hin_y[2]=−1 -> −2.
- Round trip: 2487 (normalization of 4096) -> 4095; −2487 -> −4096.
- Overflow: Hin_x[1]=20000 -> 32767 with DENORM_SAT_EN, −32602 without. Hin_x[2]=−20000 -> −32768 with, 32601 without.
- Backpressure: out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0, and a second in_valid is ignored. On out_ready=1, one handshake occurs, then in_ready=1 next cycle and the second row is accepted.
- Reset mid-RUN (rst_n low at cnt=2) -> out_valid=0, outputs 0, in_ready=1 immediately. The next row processes correctly with no residue from the aborted row.
